// File: rtl/aes256_key_expander_if.sv
// Key-load handshake and round-key read port of the AES-256 key expander.
interface aes256_key_expander_if;
  localparam int unsigned KEY_W = 256;
  localparam int unsigned RK_W  = 128;

  logic             key_start;
  logic [KEY_W-1:0] Key;
  logic             busy;
  logic             key_finished;
  logic [3:0]       rk_index;
  logic [RK_W-1:0]  round_key;

  modport master (
    output key_start, Key, rk_index,
    input  busy, key_finished, round_key
  );

  modport slave (
    input  key_start, Key, rk_index,
    output busy, key_finished, round_key
  );
endinterface

// File: rtl/aes_sbox.sv
// Shared combinational AES forward S-box: multiplicative inverse in GF(2^8)
// followed by the affine transform.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xa;
    p  = 8'h00;
    xa = x;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) p = p ^ xa;
      xa = {xa[6:0], 1'b0} ^ (xa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // Inverse as a^254 (square-and-multiply), maps 0 to 0; then affine map
  always_comb begin
    sq  = a;
    inv = 8'h01;
    for (int k = 0; k < 7; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes256_key_expander.sv
// AES-256 key schedule: expands a 256-bit key into 60 words (one per cycle)
// and serves 128-bit round keys through a registered read port.
// Optional macro AES_EQ_INV_KEY_EN: round keys 1..13 are returned through
// InvMixColumns for the equivalent inverse cipher.
module aes256_key_expander #(
  parameter int unsigned NR   = 14,
  parameter int unsigned RK_W = 128
) (
  input  logic                  CLK,
  input  logic                  RST,
  aes256_key_expander_if.slave  bus
);

  localparam int unsigned NWORDS = 4 * (NR + 1);
  localparam int unsigned IDX_W  = 6;

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             load, wr;
  logic             busy_q, kf_q;
  logic [RK_W-1:0]  rk_q, rk_d;
  logic [31:0]      w_q [NWORDS];

  logic [31:0]      prev_w, old_w, sb_in, sb_out, temp, new_w;
  logic [7:0]       rcon;
  logic [IDX_W-1:0] base;
  logic [RK_W-1:0]  raw;

`ifdef AES_EQ_INV_KEY_EN
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int k = 0; k < 4; k++) begin
      a[k]  = w[31-8*k -: 8];
      x2    = xt(a[k]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[k] = x8 ^ a[k];
      mb[k] = x8 ^ x2 ^ a[k];
      md[k] = x8 ^ x4 ^ a[k];
      me[k] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
`endif

  // State register and word counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: load key on start, then one word per cycle until w[59]
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    wr      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.key_start) begin
          state_d = EXPAND;
          idx_d   = IDX_W'(8);
          load    = 1'b1;
        end
      end
      EXPAND: begin
        wr    = 1'b1;
        idx_d = IDX_W'(idx_q + IDX_W'(1));
        if (idx_q == IDX_W'(NWORDS - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Schedule datapath: RotWord/SubWord/Rcon applied to w[i-1]
  always_comb begin
    prev_w = w_q[IDX_W'(idx_q - IDX_W'(1))];
    old_w  = w_q[IDX_W'(idx_q - IDX_W'(8))];
    sb_in  = (idx_q[2:0] == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    rcon   = 8'(8'h01 << 3'(idx_q[5:3] - 3'd1));
    case (idx_q[2:0])
      3'd0:    temp = sb_out ^ {rcon, 24'h0};
      3'd4:    temp = sb_out;
      default: temp = prev_w;
    endcase
    new_w = old_w ^ temp;
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.a(sb_in[8*b +: 8]), .s(sb_out[8*b +: 8]));
  end

  // Word store: not reset; loaded with the key, then appended during expansion
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (load) begin
        for (int k = 0; k < 8; k++) w_q[k] <= bus.Key[255-32*k -: 32];
      end else if (wr) begin
        w_q[idx_q] <= new_w;
      end
    end
  end

  // Read mux: index 15 reads as zero
  always_comb begin
    base = {rk_index_w(), 2'b00};
    raw  = {w_q[base], w_q[base | IDX_W'(1)], w_q[base | IDX_W'(2)], w_q[base | IDX_W'(3)]};
    rk_d = '0;
    if (bus.rk_index != 4'd15) begin
      rk_d = raw;
`ifdef AES_EQ_INV_KEY_EN
      if (bus.rk_index != 4'd0 && bus.rk_index != 4'd14) begin
        rk_d = {inv_mix_word(raw[127:96]), inv_mix_word(raw[95:64]),
                inv_mix_word(raw[63:32]),  inv_mix_word(raw[31:0])};
      end
`endif
    end
  end

  function automatic logic [3:0] rk_index_w();
    return bus.rk_index;
  endfunction

  // Registered status flags and round-key output
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_q <= 1'b0;
      kf_q   <= 1'b0;
      rk_q   <= '0;
    end else begin
      busy_q <= (state_d == EXPAND);
      kf_q   <= (state_d == DONE);
      rk_q   <= rk_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.key_finished = kf_q;
  assign bus.round_key    = rk_q;

endmodule

// File: tb/tb_aes256_key_expander.sv
// Self-checking bench for aes256_key_expander: known-answer table, random
// keys against a software key-schedule model, and start/abort corner cases.
module tb_aes256_key_expander;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  aes256_key_expander_if bus();
  aes256_key_expander dut (.CLK(CLK), .RST(RST), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [7:0]  sbox_t [256];
  logic [31:0] mw [60];

  localparam logic [255:0] KEY1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY2 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  typedef struct {
    logic [255:0] key;
    logic [3:0]   idx;
    logic [127:0] exp;
  } vec_t;
  vec_t vt [5];

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    int acc;
    acc = 0;
    for (int k = 0; k < 8; k++)
      if (y[k]) acc = acc ^ (int'(x) << k);
    for (int k = 14; k >= 8; k--)
      if (acc[k]) acc = acc ^ (32'h11b << (k - 8));
    return acc[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, r;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int b = 0; b < 8; b++)
        r[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8];
      sbox_t[x] = r ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int k = 0; k < 8; k++) mw[k] = key[255-32*k -: 32];
    for (int i = 8; i < 60; i++) begin
      t = mw[i-1];
      if (i % 8 == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      mw[i] = mw[i-8] ^ t;
    end
  endtask

  function automatic logic [127:0] inv_mix(input logic [127:0] k);
    logic [7:0] coef [4];
    logic [7:0] a [4];
    logic [7:0] o;
    logic [127:0] res;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = k[127 - 32*c - 8*r -: 8];
      for (int j = 0; j < 4; j++) begin
        o = 8'h00;
        for (int r = 0; r < 4; r++) o = o ^ gmul(coef[(r - j + 4) % 4], a[r]);
        res[127 - 32*c - 8*j -: 8] = o;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] view(input int r, input logic [127:0] stored);
`ifdef AES_EQ_INV_KEY_EN
    if (r >= 1 && r <= 13) return inv_mix(stored);
`endif
    return stored;
  endfunction

  function automatic logic [127:0] model_rk(input int r);
    if (r == 15) return '0;
    return view(r, {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]});
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Start an expansion, optionally pulse key_start again inside it, and time key_finished.
  task automatic expand(input logic [255:0] key, input int inject_at, input logic [255:0] inj_key);
    int cnt;
    bus.Key       = key;
    bus.key_start = 1'b1;
    tick();
    bus.key_start = 1'b0;
    bus.Key       = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    check("busy_after_start", 128'(bus.busy), 128'd1);
    check("kf_low_after_start", 128'(bus.key_finished), 128'd0);
    cnt = 0;
    while (!bus.key_finished && cnt < 100) begin
      if (cnt == inject_at) begin
        bus.key_start = 1'b1;
        bus.Key       = inj_key;
      end else begin
        bus.key_start = 1'b0;
      end
      tick();
      cnt++;
    end
    bus.key_start = 1'b0;
    check("kf_latency", 128'(cnt), 128'd52);
    check("busy_low_done", 128'(bus.busy), 128'd0);
  endtask

  task automatic read(input int r, output logic [127:0] v);
    bus.rk_index = 4'(r);
    tick();
    v = bus.round_key;
  endtask

  task automatic sweep();
    logic [127:0] v;
    for (int r = 14; r >= 0; r--) begin
      read(r, v);
      check($sformatf("sweep_idx%0d", r), v, model_rk(r));
    end
    read(15, v);
    check("idx15_zero", v, 128'h0);
  endtask

  logic [127:0] v;
  logic [255:0] last_key, rk;

  initial begin
    vt[0] = '{KEY1, 4'd0,  128'h000102030405060708090a0b0c0d0e0f};
    vt[1] = '{KEY1, 4'd1,  128'h101112131415161718191a1b1c1d1e1f};
    vt[2] = '{KEY1, 4'd2,  128'ha573c29fa176c498a97fce93a572c09c};
    vt[3] = '{KEY1, 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
    vt[4] = '{KEY2, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e};

    build_sbox();
    RST = 1'b1;
    bus.key_start = 1'b0;
    bus.Key = '0;
    bus.rk_index = 4'd3;
    tick();
    tick();
    RST = 1'b0;
    check("reset_busy", 128'(bus.busy), 128'd0);
    check("reset_kf", 128'(bus.key_finished), 128'd0);
    check("reset_round_key", bus.round_key, 128'h0);

    // Known-answer table
    last_key = '0;
    for (int n = 0; n < 5; n++) begin
      if (n == 0 || vt[n].key != last_key) expand(vt[n].key, -1, '0);
      last_key = vt[n].key;
      read(int'(vt[n].idx), v);
      check($sformatf("kat%0d_idx%0d", n, vt[n].idx), v, view(int'(vt[n].idx), vt[n].exp));
    end

    // Random keys against the model, restarted from DONE each time
    for (int n = 0; n < 3; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      model_expand(rk);
      expand(rk, -1, '0);
      sweep();
    end

    // key_start mid-expansion is ignored
    model_expand(KEY1);
    expand(KEY1, 10, KEY2);
    for (int n = 0; n < 4; n++) begin
      read(int'(vt[n].idx), v);
      check($sformatf("ignore_start_idx%0d", vt[n].idx), v, model_rk(int'(vt[n].idx)));
    end

    // Reset during expansion aborts, then a clean restart
    bus.Key = KEY2;
    bus.key_start = 1'b1;
    tick();
    bus.key_start = 1'b0;
    for (int k = 0; k < 19; k++) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("abort_busy", 128'(bus.busy), 128'd0);
    check("abort_kf", 128'(bus.key_finished), 128'd0);
    for (int k = 0; k < 60; k++) tick();
    check("abort_stays_idle", 128'(bus.key_finished), 128'd0);
    model_expand(KEY2);
    expand(KEY2, -1, '0);
    read(14, v);
    check("restart_idx14", v, vt[4].exp);
    sweep();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes256_key_expander.md
Name: aes256_key_expander

Overview:
Upstream key-schedule stage for the AES-256 decryption core. It accepts a 256-bit cipher key and generates all 15 round keys, one 32-bit word per cycle, storing them in a local register file. The decryption core then reads round keys by index, in any order (normally 14 down to 0), through a registered read port.

Parameters:
NR, 14, number of AES rounds; fixes storage at 4*(NR+1)=60 words; only 14 supported.
RK_W, 128, round-key width in bits.

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  synchronous, active-high reset.
key_start  in  1  1-cycle request to expand Key; sampled only in IDLE or DONE.
Key  in  256  cipher key; Key[255:224] is w[0]; sampled on the key_start edge only.
busy  out  1  high while expanding.
key_finished  out  1  level; high in DONE, meaning all 15 round keys are valid.
rk_index  in  4  round-key select, 0..14.
round_key  out  128  registered round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}, r = rk_index of the previous cycle.

Behaviour:
- Reset values: RST=1 at an edge forces state=IDLE, busy=0, key_finished=0, round_key=0, word counter i=0. The word store is not cleared.
- FSM states:
  - IDLE: waits for key_start.
  - EXPAND: writes one word per cycle.
  - DONE: keys valid; key_finished=1.
- Transition IDLE/DONE -> EXPAND on key_start=1 (edge E0):
  - Key is loaded into w[0..7]; i=8; busy=1; key_finished=0.
- EXPAND, per edge:
  - temp = w[i-1].
  - If i%8==0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/8],24'h0}, with Rcon = 01,02,04,08,10,20,40.
  - Else if i%8==4: temp = SubWord(temp).
  - w[i] = w[i-8] ^ temp; i = i+1.
- Expansion finishes at edge E52, which writes w[59]. At E52: state=DONE, busy=0, key_finished=1.
  - key_finished is first high in the cycle after E52, i.e. 52 cycles after the sampling edge.
- SubWord uses the codebase's shared combinational forward S-box module, 4 instances, on the temp path. No S-box table lives in this block.
- key_start while in EXPAND is ignored; the expansion in progress completes unaltered.
- key_start while in DONE starts a fresh expansion. key_finished drops at E0.
- RST during EXPAND aborts expansion: state returns to IDLE and key_finished=0. A later key_start restarts cleanly from w[0].
- Read port:
  - round_key updates every edge from rk_index (1-cycle latency), in every state.
  - Contents are guaranteed only while key_finished=1.
  - rk_index 15 returns 128'h0.
- A read of an index concurrent with a write to it returns the pre-write value.

Optional Feature:
AES_EQ_INV_KEY_EN:
- Defined: for rk_index 1..13, round_key = InvMixColumns(stored round key), supporting the equivalent inverse cipher. Indices 0 and 14 are unmodified. Read latency stays 1 cycle; the InvMixColumns logic sits before the output register.
- Undefined: round_key is always the raw stored key, and no InvMixColumns logic is instantiated.

Test Plan:
1. RST, then key_start with Key=000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f -> key_finished rises exactly 52 cycles after the key_start edge. Reads return:
   - idx0 = 000102030405060708090a0b0c0d0e0f
   - idx1 = 101112131415161718191a1b1c1d1e1f
   - idx2 = a573c29fa176c498a97fce93a572c09c
   - idx14 = 24fc79ccbf0979e9371ac23c6d68de36
2. Key=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> idx14 = fe4890d1e6188d0b046df344706c631e.
3. Pulse key_start at cycle 10 of expansion with a different Key -> it is ignored; results match scenario 1 and key_finished timing is unchanged.
4. Assert RST at cycle 20 of expansion -> busy=0 and key_finished=0 next cycle. A re-run with the scenario 2 key gives correct idx14.
5. rk_index=15 in DONE -> round_key=0 one cycle later. Sweeping rk_index 14..0 on consecutive cycles returns the keys in matching order with 1-cycle latency.
6. With AES_EQ_INV_KEY_EN defined, scenario 1 key:
   - idx0 and idx14 are unchanged.
   - idx1..13 equal InvMixColumns of the scenario 1 values, checked against the software model.
